// File: rtl/sha256_wsched_ctrl.sv
// SHA-256 message-schedule controller.
// Takes a 16-word block, then streams W[0..ROUNDS-1] through a registered
// valid/ready port, expanding W[16..] with one shared 4:2 carry-save reducer
// followed by a single carry-propagate add.

module reduce4to2_nbit #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_c,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_cn4,
    output logic [WIDTH-1:0] o_sn4
);
    logic [WIDTH-1:0] s1_s;
    logic [WIDTH-1:0] maj1_s;
    logic [WIDTH-1:0] c1_s;
    logic [WIDTH-1:0] maj2_s;

    // Two cascaded carry-save rows: (a,b,c) then (sum,carry,d); carries out of the MSB drop
    always_comb begin
        s1_s   = i_a ^ i_b ^ i_c;
        maj1_s = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);
        c1_s   = {maj1_s[WIDTH-2:0], 1'b0};
        o_sn4  = s1_s ^ c1_s ^ i_d;
        maj2_s = (s1_s & c1_s) | (s1_s & i_d) | (c1_s & i_d);
        o_cn4  = {maj2_s[WIDTH-2:0], 1'b0};
    end
endmodule

module sha256_wsched_ctrl #(
    parameter int WIDTH  = 32,
    parameter int ROUNDS = 64
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_m_valid,
    input  logic [WIDTH-1:0] i_m_data,
    output logic             o_m_ready,
    output logic             o_w_valid,
    output logic [WIDTH-1:0] o_w_data,
    output logic [5:0]       o_w_idx,
    input  logic             i_w_ready,
    output logic             o_busy,
    output logic             o_done
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CALC = 2'd2,
        ST_EMIT = 2'd3
    } state_e;

    localparam logic [5:0] LAST_IDX = 6'(ROUNDS - 1);

    state_e           state_q, state_d;
    logic [5:0]       t_q, t_d;
    logic [WIDTH-1:0] win_q [16];
    logic [WIDTH-1:0] win_d [16];
    logic [WIDTH-1:0] c_q, c_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             w_valid_q, w_valid_d;
    logic [WIDTH-1:0] w_data_q, w_data_d;
    logic [5:0]       w_idx_q, w_idx_d;
    logic             done_q, done_d;

    logic             load_en_s;
    logic             m_ready_s;
    logic             shift_en_s;
    logic [WIDTH-1:0] shift_word_s;
    logic [WIDTH-1:0] red_a_s;
    logic [WIDTH-1:0] red_c_s;
    logic [WIDTH-1:0] red_cn_s;
    logic [WIDTH-1:0] red_sn_s;
    logic [WIDTH-1:0] sum_s;

    function automatic logic [31:0] rotr32(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return rotr32(x, 7) ^ rotr32(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return rotr32(x, 17) ^ rotr32(x, 19) ^ (x >> 10);
    endfunction

    // Reducer operands come straight from the window: W[t-2], W[t-7], W[t-15], W[t-16]
    always_comb begin
        red_a_s   = sigma1(win_q[1]);
        red_c_s   = sigma0(win_q[14]);
        sum_s     = c_q + s_q;
        load_en_s = !w_valid_q || i_w_ready;
    end

    reduce4to2_nbit #(.WIDTH(WIDTH)) u_reduce (
        .i_a   (red_a_s),
        .i_b   (win_q[6]),
        .i_c   (red_c_s),
        .i_d   (win_q[15]),
        .o_cn4 (red_cn_s),
        .o_sn4 (red_sn_s)
    );

    // Next state, window shift and output-register load; a shift always coincides with a load
    always_comb begin
        state_d      = state_q;
        t_d          = t_q;
        win_d        = win_q;
        c_d          = c_q;
        s_d          = s_q;
        w_data_d     = w_data_q;
        w_idx_d      = w_idx_q;
        done_d       = 1'b0;
        m_ready_s    = 1'b0;
        shift_en_s   = 1'b0;
        shift_word_s = {WIDTH{1'b0}};

        if (w_valid_q && i_w_ready) begin
            w_valid_d = 1'b0;
        end else begin
            w_valid_d = w_valid_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_LOAD;
                    t_d     = 6'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                m_ready_s = load_en_s;
                if (load_en_s && i_m_valid) begin
                    shift_en_s   = 1'b1;
                    shift_word_s = i_m_data;
                    if (t_q == 6'd15) begin
                        state_d = ST_CALC;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_CALC: begin
                c_d     = red_cn_s;
                s_d     = red_sn_s;
                state_d = ST_EMIT;
            end
            ST_EMIT: begin
                if (load_en_s) begin
                    shift_en_s   = 1'b1;
                    shift_word_s = sum_s;
                    if (t_q == LAST_IDX) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_CALC;
                    end
                end else begin
                    state_d = ST_EMIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (shift_en_s) begin
            for (int i = 15; i > 0; i--) begin
                win_d[i] = win_q[i-1];
            end
            win_d[0]  = shift_word_s;
            w_valid_d = 1'b1;
            w_data_d  = shift_word_s;
            w_idx_d   = t_q;
            t_d       = t_q + 6'd1;
        end else begin
            win_d = win_q;
        end
    end

    // State, window, carry-save and output registers; reset drops all progress
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            t_q       <= 6'd0;
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= {WIDTH{1'b0}};
            end
            c_q       <= {WIDTH{1'b0}};
            s_q       <= {WIDTH{1'b0}};
            w_valid_q <= 1'b0;
            w_data_q  <= {WIDTH{1'b0}};
            w_idx_q   <= 6'd0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            t_q       <= t_d;
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= win_d[i];
            end
            c_q       <= c_d;
            s_q       <= s_d;
            w_valid_q <= w_valid_d;
            w_data_q  <= w_data_d;
            w_idx_q   <= w_idx_d;
            done_q    <= done_d;
        end
    end

    // Port mapping
    always_comb begin
        o_m_ready = m_ready_s;
        o_w_valid = w_valid_q;
        o_w_data  = w_data_q;
        o_w_idx   = w_idx_q;
        o_busy    = (state_q != ST_IDLE);
        o_done    = done_q;
    end
endmodule

// File: tb/tb_sha256_wsched_ctrl.sv
// Bench for sha256_wsched_ctrl: known-answer table, random blocks with
// handshake gaps against a plain-arithmetic schedule model, reset and
// short-schedule scenarios.
`timescale 1ns/1ps
module tb_sha256_wsched_ctrl;
    logic        clk      = 1'b0;
    logic        rst      = 1'b1;
    logic        start    = 1'b0;
    logic        m_valid  = 1'b0;
    logic [31:0] m_data   = 32'd0;
    logic        w_ready  = 1'b1;
    logic        m_ready, w_valid, busy, done;
    logic [31:0] w_data;
    logic [5:0]  w_idx;
    logic        m_ready20, w_valid20, busy20, done20;
    logic [31:0] w_data20;
    logic [5:0]  w_idx20;

    sha256_wsched_ctrl #(.WIDTH(32), .ROUNDS(64)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_m_valid(m_valid), .i_m_data(m_data),
        .o_m_ready(m_ready), .o_w_valid(w_valid), .o_w_data(w_data), .o_w_idx(w_idx),
        .i_w_ready(w_ready), .o_busy(busy), .o_done(done));

    sha256_wsched_ctrl #(.WIDTH(32), .ROUNDS(20)) dut20 (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_m_valid(m_valid), .i_m_data(m_data),
        .o_m_ready(m_ready20), .o_w_valid(w_valid20), .o_w_data(w_data20), .o_w_idx(w_idx20),
        .i_w_ready(w_ready), .o_busy(busy20), .o_done(done20));

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct { logic [31:0] d; logic [5:0] i; } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    logic [31:0] blk [16];
    logic [31:0] mw  [64];

    typedef struct {
        logic [31:0] m0; logic [31:0] m1; logic [31:0] m15;
        logic [31:0] e16; logic [31:0] e17;
    } vec_t;
    vec_t tbl [3];

    bit          mon_en = 1'b0, no_mr_chk = 1'b0, rnd_rdy = 1'b0, mon20_en = 1'b0;
    bit          stall_prev = 1'b0, done_prev = 1'b0;
    logic [31:0] prev_d = 32'd0, cap16 = 32'd0, cap17 = 32'd0;
    logic [5:0]  prev_i = 6'd0, done_idx = 6'd0;
    int          done_cnt = 0, taken_cnt = 0, start_mark = 0, done_cyc = 0;
    int          n20 = 0, d20cnt = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%08h required 0x%08h", nm, act, req);
        end
    endtask

    task automatic fail(input string nm);
        total++;
        bad++;
        $display("FAIL %s: got no event within bound, required event", nm);
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Straight FIPS-180 recurrence over a 64-entry array
    task automatic build_model();
        for (int t = 0; t < 64; t++) begin
            if (t < 16) mw[t] = blk[t];
            else mw[t] = (rotr(mw[t-2], 17) ^ rotr(mw[t-2], 19) ^ (mw[t-2] >> 10)) + mw[t-7]
                       + (rotr(mw[t-15], 7) ^ rotr(mw[t-15], 18) ^ (mw[t-15] >> 3)) + mw[t-16];
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        w_ready = rnd_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
    end

    // Output monitor / scoreboard, sampled on the falling edge
    initial forever begin
        @(negedge clk);
        if (mon_en) begin
            if (stall_prev) begin
                check("stall_data", w_data, prev_d);
                check("stall_idx", {26'd0, w_idx}, {26'd0, prev_i});
            end
            if (done_prev) check("busy_after_done", {31'd0, busy}, 32'd0);
            if (no_mr_chk) check("m_ready_low", {31'd0, m_ready}, 32'd0);
            if (start && !busy) start_mark = cyc;
            if (done) begin
                done_cnt++;
                done_idx = w_idx;
                done_cyc = cyc;
                check("done_valid", {31'd0, w_valid}, 32'd1);
            end
            if (w_valid && w_ready) begin
                if (exp_q.size() == 0) begin
                    fail("extra_word");
                end else begin
                    mon_e = exp_q.pop_front();
                    check("w_data", w_data, mon_e.d);
                    check("w_idx", {26'd0, w_idx}, {26'd0, mon_e.i});
                    taken_cnt++;
                    if (w_idx == 6'd16) cap16 = w_data;
                    if (w_idx == 6'd17) cap17 = w_data;
                end
            end
            stall_prev = w_valid && !w_ready;
            prev_d     = w_data;
            prev_i     = w_idx;
            done_prev  = done;
        end else begin
            stall_prev = 1'b0;
            done_prev  = 1'b0;
        end
        if (mon20_en) begin
            if (w_valid20 && w_ready) begin
                if (n20 < 64) check("r20_data", w_data20, mw[n20]);
                check("r20_idx", {26'd0, w_idx20}, 32'(n20));
                n20++;
            end
            if (done20) begin
                d20cnt++;
                check("r20_done_idx", {26'd0, w_idx20}, 32'd19);
            end
        end
    end

    task automatic do_reset();
        mon_en = 1'b0; no_mr_chk = 1'b0;
        rst = 1'b1; start = 1'b0; m_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        mon_en = 1'b1;
    endtask

    task automatic start_and_load(input bit rnd, input bit poke);
        bit ok;
        build_model();
        for (int t = 0; t < 64; t++) exp_q.push_back('{mw[t], 6'(t)});
        done_cnt = 0; taken_cnt = 0;
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (rnd) begin
                m_valid = 1'b0;
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
            m_data  = blk[k];
            m_valid = 1'b1;
            if (poke && k == 5) start = 1'b1;
            ok = 1'b0;
            for (int g = 0; g < 300; g++) begin
                @(negedge clk);
                if (m_ready) begin ok = 1'b1; break; end
            end
            if (!ok) fail("load_timeout");
            @(posedge clk); #1;
            start = 1'b0;
        end
        m_valid   = poke;
        m_data    = 32'hDEADBEEF;
        no_mr_chk = 1'b1;
    endtask

    task automatic finish_block(input bit rnd, input bit poke);
        bit ok;
        if (poke) begin
            ok = 1'b0;
            for (int g = 0; g < 1000; g++) begin
                @(negedge clk);
                if (taken_cnt >= 30) begin ok = 1'b1; break; end
            end
            if (!ok) fail("emit_poke_timeout");
            @(posedge clk); #1; start = 1'b1;
            @(posedge clk); #1; start = 1'b0;
        end
        ok = 1'b0;
        for (int g = 0; g < 3000; g++) begin
            @(negedge clk);
            if (done_cnt >= 1) begin ok = 1'b1; break; end
        end
        if (!ok) fail("done_timeout");
        repeat (3) @(negedge clk);
        check("done_count", 32'(done_cnt), 32'd1);
        check("done_idx", {26'd0, done_idx}, 32'd63);
        if (!rnd) begin
            check("words_taken", 32'(taken_cnt), 32'd64);
            check("queue_empty", 32'(exp_q.size()), 32'd0);
        end
        m_valid = 1'b0; no_mr_chk = 1'b0;
    endtask

    initial begin
        bit ok;
        tbl[0] = '{32'h61626380, 32'h00000000, 32'h00000018, 32'h61626380, 32'h000F0000};
        tbl[1] = '{32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000};
        tbl[2] = '{32'h00000000, 32'h00000001, 32'h00000000, 32'h02004000, 32'h00000001};

        #2;
        check("rst_w_valid", {31'd0, w_valid}, 32'd0);
        check("rst_w_data", w_data, 32'd0);
        check("rst_w_idx", {26'd0, w_idx}, 32'd0);
        check("rst_m_ready", {31'd0, m_ready}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);

        // Known-answer blocks, consumer always ready; the ROUNDS=20 instance rides on entry 0
        for (int v = 0; v < 3; v++) begin
            do_reset();
            for (int k = 0; k < 16; k++) blk[k] = 32'd0;
            blk[0] = tbl[v].m0; blk[1] = tbl[v].m1; blk[15] = tbl[v].m15;
            n20 = 0; d20cnt = 0; mon20_en = (v == 0);
            start_and_load(1'b0, 1'b0);
            finish_block(1'b0, 1'b0);
            mon20_en = 1'b0;
            check("kat_w16", cap16, tbl[v].e16);
            check("kat_w17", cap17, tbl[v].e17);
            check("kat_cycles", 32'(done_cyc - start_mark), 32'd113);
            if (v == 0) begin
                check("r20_words", 32'(n20), 32'd20);
                check("r20_done_count", 32'(d20cnt), 32'd1);
            end
        end

        // Asynchronous reset in the middle of expansion, then a clean abc block
        do_reset();
        for (int k = 0; k < 16; k++) blk[k] = 32'd0;
        blk[0] = 32'h61626380; blk[15] = 32'h00000018;
        start_and_load(1'b0, 1'b0);
        ok = 1'b0;
        for (int g = 0; g < 300; g++) begin
            @(negedge clk);
            if (w_valid && w_idx == 6'd30) begin ok = 1'b1; break; end
        end
        if (!ok) fail("idx30_timeout");
        #2;
        mon_en = 1'b0;
        rst = 1'b1;
        #1;
        check("arst_w_valid", {31'd0, w_valid}, 32'd0);
        check("arst_w_data", w_data, 32'd0);
        check("arst_w_idx", {26'd0, w_idx}, 32'd0);
        check("arst_m_ready", {31'd0, m_ready}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_done", {31'd0, done}, 32'd0);
        do_reset();
        start_and_load(1'b0, 1'b0);
        finish_block(1'b0, 1'b0);
        check("post_rst_w16", cap16, 32'h61626380);

        // Random blocks with handshake gaps, stray starts and stray message valids
        do_reset();
        rnd_rdy = 1'b1;
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < 16; k++) blk[k] = $urandom();
            start_and_load(1'b1, b[0]);
            finish_block(1'b1, b[0]);
        end
        ok = 1'b0;
        for (int g = 0; g < 200; g++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin ok = 1'b1; break; end
        end
        if (!ok) fail("drain_timeout");
        check("rand_queue_empty", 32'(exp_q.size()), 32'd0);
        rnd_rdy = 1'b0;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/sha256_wsched_ctrl.md
# sha256_wsched_ctrl

SHA-256 message-schedule controller. It accepts one 16-word message block, then emits the 64-word schedule W[0..63] in order through a single registered valid/ready output. It sequences a single shared 4-to-2 carry-save reducer (reduce4to2_nbit, WIDTH=32) plus one 32-bit carry-propagate add to expand W[16..63]. It sits between the block-padding front end and the round engine.

## Interface
- WIDTH, 32: word width; only 32 is supported.
- ROUNDS, 64: number of schedule words emitted per block; legal range 17..64.
- i_clk  in  1  rising-edge clock.
- i_rst  in  1  asynchronous active-high reset.
- i_start  in  1  start a new block; honoured only in IDLE.
- i_m_valid  in  1  message word valid.
- i_m_data  in  32  message word, big-endian word order, M[0] first.
- o_m_ready  out  1  message word accepted this cycle when high with i_m_valid.
- o_w_valid  out  1  schedule word valid (registered).
- o_w_data  out  32  W[t].
- o_w_idx  out  6  t of the word currently on o_w_data.
- i_w_ready  in  1  consumer takes the word when high with o_w_valid.
- o_busy  out  1  high in any state other than IDLE.
- o_done  out  1  one-cycle pulse when W[ROUNDS-1] is loaded into the output register.

## Operation
- Storage: 16x32 window shift register, win[0] = newest word; 6-bit counter t; one-entry output register; carry/sum registers c_r, s_r.
- load_en = !o_w_valid || i_w_ready. The output register is written only when load_en is high. o_w_valid clears when a word is taken and nothing new is loaded.
- States:
  - IDLE: i_start -> LOAD, t=0.
  - LOAD: o_m_ready = load_en. On an accepted word: shift it into win[0], load the output register (data=word, idx=t), t++. After t=15 is accepted -> CALC.
  - CALC: drive the reducer with a=σ1(win[1]), b=win[6], c=σ0(win[14]), d=win[15] (W[t-2], W[t-7], W[t-15], W[t-16]); register o_cn4 -> c_r and o_sn4 -> s_r. Always -> EMIT.
  - EMIT: W = c_r + s_r mod 2^32. If load_en: shift W into win[0], output register <= (W, t), t++. If the emitted t == ROUNDS-1, pulse o_done and go to IDLE; otherwise go to CALC. If load_en is low, stay in EMIT with c_r/s_r held.
- σ0(x) = ROTR7 ^ ROTR18 ^ SHR3. σ1(x) = ROTR17 ^ ROTR19 ^ SHR10. All additions wrap mod 2^32; carries out of bit 31 are discarded.
- i_start outside IDLE is ignored. i_m_valid outside LOAD is ignored and o_m_ready is held low.
- The last word stays in the output register after the controller returns to IDLE until it is taken. A new block may start while that word is pending, but LOAD stalls until load_en.
- Reset values: state=IDLE, t=0, window=0, c_r=s_r=0, o_w_valid=0, o_w_data=0, o_w_idx=0, o_m_ready=0, o_busy=0, o_done=0. Reset mid-block discards all progress immediately, with no partial completion.

## Timing
- i_start sampled in cycle k: LOAD in k+1, o_m_ready may be high from k+1.
- LOAD: 1 word per cycle with a continuously ready consumer. A word accepted at edge e is visible on o_w_data after e.
- Expansion: 2 cycles per word (CALC, EMIT). W[16] is visible 2 cycles after M[15] is accepted.
- Full block with no backpressure: 1 (start) + 16 + 2*(ROUNDS-16) cycles; 113 for ROUNDS=64.
- Backpressure: while i_w_ready=0 with o_w_valid=1, o_w_data/o_w_idx are stable and the FSM holds in LOAD (o_m_ready=0) or EMIT.
- o_done is asserted in the same cycle o_w_idx becomes ROUNDS-1 with o_w_valid=1.

## Test plan
- "abc" block (M0=0x61626380, M1..M14=0, M15=0x00000018), i_w_ready=1 -> W[16]=0x61626380, W[17]=0x000F0000, indices 0..63 in order, o_done once at idx 63, 113 cycles total.
- All-zero block -> 64 words all 0x00000000, o_busy drops the cycle after o_done.
- Random blocks with random i_w_ready and i_m_valid gaps -> stream bit-exact against a reference model, no word dropped or duplicated, o_w_data stable while stalled.
- i_start pulsed mid-LOAD and mid-EMIT -> ignored, sequence unchanged. i_m_valid asserted during CALC/EMIT -> o_m_ready=0 and no word consumed.
- i_rst asserted asynchronously at t=30 -> all outputs return to their reset values at once. A following "abc" block reproduces W[16]=0x61626380.
- ROUNDS=20 -> exactly 20 words, o_done at idx 19.
